mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one mux4 (4->1 bit mux) between four requesters.

---
 rtl/mux4_rr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that shares one 4->1 single-bit mux between four
//   requesters. The registered grant drives the mux select. A grant is held
//   while its owner keeps requesting. When other requesters are waiting, the
//   grant is limited to HOLD_MAX consecutive cycles.
//
//   Request/grant protocol: a requester raises req[i] and holds it until it
//   is done. It owns the shared bit while gnt[i]=1. Dropping req[i] releases
//   ownership at the next rising edge. valid is high exactly while some gnt
//   bit is high. While valid is high, z carries d[sel]; otherwise z is 0.
//
//   Optional feature: define MUX4_ARB_LOCK_EN to add the lock input. While
//   the owner requests with lock=1, it cannot be preempted.
//
// Parameters
//   HOLD_MAX  max consecutive grant cycles under contention (>=1)
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [3:0] request per requester
//   d      in   [3:0] data bit per requester (mux input i)
//   lock   in   owner suppresses preemption (MUX4_ARB_LOCK_EN only)
//   gnt    out  [3:0] one-hot registered grant, 0000 when idle
//   sel    out  [1:0] binary index of the owner / mux select
//   valid  out  a grant is active
//   z      out  shared mux output, gated by valid
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
`ifdef MUX4_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       z
);

    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [3:0] scan_req;
    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_found;
    logic       owner_req;
    logic       others_req;
    logic       preempt_en;
    logic       mux_y;

`ifdef MUX4_ARB_LOCK_EN
    assign preempt_en = ~lock;
`else
    assign preempt_en = 1'b1;
`endif

    // In GRANT, gnt_q marks the current owner. Masking it out means a
    // replacement never re-picks the owner. In IDLE, gnt_q is zero, so all
    // requesters are eligible.
    assign scan_req   = req & ~gnt_q;
    assign owner_req  = |(req & gnt_q);
    assign others_req = |scan_req;

    // Scan ptr+1, ptr+2, ptr+3, ptr+4 (= ptr) modulo 4. Take the first hit.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_found && scan_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'd3;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    ptr_d   = win_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    if (others_req) begin
                        // Hand over directly, with no idle cycle in between.
                        gnt_d  = 4'b0001 << win_idx;
                        sel_d  = win_idx;
                        ptr_d  = win_idx;
                        hold_d = '0;
                    end else begin
                        // sel keeps its last value while idle.
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (others_req && preempt_en && hold_q == HOLD_LAST) begin
                    gnt_d  = 4'b0001 << win_idx;
                    sel_d  = win_idx;
                    ptr_d  = win_idx;
                    hold_d = '0;
                end else if (hold_q != HOLD_LAST) begin
                    // Saturate instead of wrapping. A long uncontended hold
                    // stays ready to yield as soon as anyone else asks.
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // Output logic, including the shared 4->1 mux
    always_comb begin
        gnt   = gnt_q;
        sel   = sel_q;
        valid = (state_q == GRANT);
        case (sel_q)
            2'd0:    mux_y = d[0];
            2'd1:    mux_y = d[1];
            2'd2:    mux_y = d[2];
            default: mux_y = d[3];
        endcase
        z = valid & mux_y;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
//   Directed testbench for mux4_rr_arbiter with HOLD_MAX = 8. Each expected
//   value is hand-derived from the round-robin rules. The reset pointer is 3,
//   so the first grant after reset goes to requester 0.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic       lock;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       z;

    int n_checks;
    int n_errors;

    mux4_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .d     (d),
`ifdef MUX4_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .z     (z)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Driver: advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] exp_gnt,
                               input logic [1:0] exp_sel, input logic exp_valid);
        check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, ".sel"}, 32'(sel), 32'(exp_sel));
        check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    endtask

    logic [3:0] exp_g;
    logic [1:0] exp_s;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        d     = 4'b0000;
        lock  = 1'b0;

        step();
        step();
        check_grant("reset", 4'b0000, 2'd0, 1'b0);
        check("reset.z", 32'(z), 32'd0);
        rst_n = 1'b1;

        // Single requester 2; z follows d[2] combinationally.
        req = 4'b0100;
        d   = 4'b0100;
        step();
        check_grant("single2", 4'b0100, 2'd2, 1'b1);
        check("single2.z", 32'(z), 32'd1);
        d = 4'b1011;
        #1;
        check("single2.z_low", 32'(z), 32'd0);
        req = 4'b0000;
        d   = 4'b0100;
        step();
        check_grant("release2", 4'b0000, 2'd2, 1'b0);
        check("release2.z", 32'(z), 32'd0);

        // With ptr = 2, the scan order is 3, 0, ...; requester 0 wins.
        req = 4'b0001;
        d   = 4'b0001;
        step();
        check_grant("grant0", 4'b0001, 2'd0, 1'b1);
        check("grant0.z", 32'(z), 32'd1);

        // Asynchronous reset in the middle of a cycle.
        #3;
        rst_n = 1'b0;
        #1;
        check_grant("async_rst", 4'b0000, 2'd0, 1'b0);
        check("async_rst.z", 32'(z), 32'd0);

        // Release reset with everyone requesting. The pointer is back at 3,
        // so owners go 0,1,2,3,0, with 8 cycles each.
        req   = 4'b1111;
        d     = 4'b1010;
        rst_n = 1'b1;
        step();
        for (int i = 0; i <= 32; i++) begin
            exp_s = 2'((i / 8) % 4);
            exp_g = 4'b0001 << exp_s;
            check_grant($sformatf("rot%0d", i), exp_g, exp_s, 1'b1);
            check($sformatf("rot%0d.z", i), 32'(z), 32'(d[exp_s]));
            if (i < 32) step();
        end

        // Owner 0 drops just as requesters 1 and 3 arrive. The grant moves
        // to 1 with no bubble.
        req = 4'b1010;
        step();
        check_grant("handover", 4'b0010, 2'd1, 1'b1);

        req = 4'b0000;
        step();
        check_grant("idle", 4'b0000, 2'd1, 1'b0);

        // Requester 3 alone for 20 cycles. The hold counter saturates.
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            step();
            check(
                $sformatf("alone3_%0d", i), 32'(gnt), 32'(4'b1000));
        end
        // Requester 0 arrives. Owner 3 is already saturated, so it yields at once.
        req = 4'b1001;
        step();
        check_grant("preempt3", 4'b0001, 2'd0, 1'b1);
        // A fresh owner 0 keeps the grant for 8 cycles, then yields to 3.
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("hold0_%0d", i), 32'(gnt), 32'(4'b0001));
        end
        step();
        check_grant("preempt0", 4'b1000, 2'd3, 1'b1);

`ifdef MUX4_ARB_LOCK_EN
        // Owner 3 leaves and 0 takes over. With lock held, 0 keeps the grant
        // despite requester 1 waiting.
        req = 4'b0001;
        step();
        check_grant("lock_own0", 4'b0001, 2'd0, 1'b1);
        req  = 4'b0011;
        lock = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("locked_%0d", i), 32'(gnt), 32'(4'b0001));
        end
        lock = 1'b0;
        step();
        check_grant("unlock", 4'b0010, 2'd1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
